// File: rtl/button_event_queue.sv
// Button event queue: a round-robin arbiter over debounced press detectors.
// Each grant acknowledges one detector for a single cycle. It also pushes
// that detector's index into a show-ahead FIFO, which the consumer drains.
module button_event_queue #(
    parameter int NUM_BUTTONS = 4,
    parameter int IDX_W       = 2,
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int CNT_W       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] wasPressed,
    output logic [NUM_BUTTONS-1:0] ackPress,
    input  logic                   popEvent,
    output logic                   eventValid,
    output logic [IDX_W-1:0]       eventIndex,
    output logic [CNT_W-1:0]       eventCount
);

    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_ACK = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NUM_BUTTONS-1:0] ack_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [IDX_W-1:0]       last_grant_q;
    logic [IDX_W-1:0]       mem_q [DEPTH];

    logic [NUM_BUTTONS-1:0] eligible_s;
    logic                   grant_found_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   pop_ok_s;
    logic                   full_s;
    logic                   grant_s;

    // Round-robin search: first eligible detector strictly after the last grant, wrapping around
    always_comb begin
        int               cand_v;
        logic [IDX_W-1:0] cand_idx_v;
        eligible_s    = wasPressed & ~ack_q;
        grant_found_s = 1'b0;
        grant_idx_s   = {IDX_W{1'b0}};
        cand_v        = 0;
        cand_idx_v    = {IDX_W{1'b0}};
        for (int i = 1; i <= NUM_BUTTONS; i++) begin
            cand_v = int'(last_grant_q) + i;
            if (cand_v >= NUM_BUTTONS) begin
                cand_v = cand_v - NUM_BUTTONS;
            end else begin
                cand_v = cand_v;
            end
            cand_idx_v = IDX_W'(cand_v);
            if (!grant_found_s && eligible_s[cand_idx_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant qualification and occupancy next-state; a pop frees a slot for a push on the same edge
    always_comb begin
        pop_ok_s = popEvent && (count_q != {CNT_W{1'b0}});
        full_s   = (count_q == CNT_W'(DEPTH));
        grant_s  = (state_q == ST_ARB) && grant_found_s && (!full_s || pop_ok_s);
        case ({grant_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbitration FSM, registered acknowledge pulse, FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_ARB;
            ack_q        <= {NUM_BUTTONS{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            last_grant_q <= IDX_W'(NUM_BUTTONS - 1);
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (grant_s) begin
                        ack_q        <= {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << grant_idx_s;
                        last_grant_q <= grant_idx_s;
                        state_q      <= ST_ACK;
                    end else begin
                        ack_q        <= {NUM_BUTTONS{1'b0}};
                        state_q      <= ST_ARB;
                    end
                end
                ST_ACK: begin
                    // The detector sees the ack at this edge, so it cannot be granted twice
                    ack_q   <= {NUM_BUTTONS{1'b0}};
                    state_q <= ST_ARB;
                end
                default: begin
                    ack_q   <= {NUM_BUTTONS{1'b0}};
                    state_q <= ST_ARB;
                end
            endcase
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            if (grant_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage: write the granted index; contents need no reset because count gates validity
    always_ff @(posedge clock) begin
        if (grant_s) begin
            mem_q[wr_ptr_q] <= grant_idx_s;
        end
    end

    assign ackPress   = ack_q;
    assign eventValid = (count_q != {CNT_W{1'b0}});
    assign eventCount = count_q;
    assign eventIndex = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue: directed vector table,
// hand-written corner sequences, then random traffic against a queue-based model.
module tb_button_event_queue;

    localparam int NB    = 4;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset;
    logic [NB-1:0] wasPressed;
    logic [NB-1:0] ackPress;
    logic          popEvent;
    logic          eventValid;
    logic [1:0]    eventIndex;
    logic [3:0]    eventCount;

    int checks = 0;
    int errors = 0;

    // Reference model state: FIFO as a queue, ack as the outstanding pulse
    int       q_m[$];
    logic [3:0] ack_m;
    int       last_m;

    button_event_queue #(
        .NUM_BUTTONS(4), .IDX_W(2), .DEPTH(8), .PTR_W(3), .CNT_W(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wasPressed(wasPressed),
        .ackPress  (ackPress),
        .popEvent  (popEvent),
        .eventValid(eventValid),
        .eventIndex(eventIndex),
        .eventCount(eventCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] wp;
        logic       pop;
        logic [3:0] ack;
        logic       valid;
        logic [3:0] cnt;
        logic [1:0] idx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge from the rules, then clock the DUT
    task automatic drive_cycle(input logic r, input logic [3:0] wp, input logic p, input bit do_chk);
        bit pop_ok;
        bit found;
        int g;
        reset      = r;
        wasPressed = wp;
        popEvent   = p;
        if (!r) begin
            q_m.delete();
            ack_m  = 4'b0000;
            last_m = NB - 1;
        end else begin
            pop_ok = p && (q_m.size() > 0);
            found  = 1'b0;
            g      = 0;
            if (ack_m == 4'b0000) begin
                for (int k = 1; k <= NB; k++) begin
                    if (!found && wp[(last_m + k) % NB]) begin
                        found = 1'b1;
                        g     = (last_m + k) % NB;
                    end
                end
            end
            if (found && !(q_m.size() < DEPTH || pop_ok)) found = 1'b0;
            if (pop_ok) void'(q_m.pop_front());
            if (found) begin
                q_m.push_back(g);
                ack_m  = 4'(1 << g);
                last_m = g;
            end else begin
                ack_m = 4'b0000;
            end
        end
        @(posedge clock);
        #1;
        if (do_chk) begin
            chk("model_ack", 32'(ackPress), 32'(ack_m));
            chk("model_valid", 32'(eventValid), 32'(q_m.size() > 0));
            chk("model_count", 32'(eventCount), 32'(q_m.size()));
            if (q_m.size() > 0) chk("model_index", 32'(eventIndex), 32'(q_m[0]));
        end
    endtask

    vec_t tbl[26];

    initial begin
        reset      = 1'b0;
        wasPressed = 4'b1111;
        popEvent   = 1'b0;
        ack_m      = 4'b0000;
        last_m     = NB - 1;

        //               rst   wp       pop   ack      vld   cnt    idx
        tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[2]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'd1, 2'd2};
        tbl[3]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'd1, 2'd2};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'd1, 2'd2};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 4'd1, 2'd0};
        tbl[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'd1, 2'd0};
        tbl[9]  = '{1'b1, 4'b1110, 1'b0, 4'b0010, 1'b1, 4'd2, 2'd0};
        tbl[10] = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1, 4'd2, 2'd0};
        tbl[11] = '{1'b1, 4'b1100, 1'b0, 4'b0100, 1'b1, 4'd3, 2'd0};
        tbl[12] = '{1'b1, 4'b1100, 1'b0, 4'b0000, 1'b1, 4'd3, 2'd0};
        tbl[13] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'd4, 2'd0};
        tbl[14] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 4'd4, 2'd0};
        tbl[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'd3, 2'd1};
        tbl[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'd2, 2'd2};
        tbl[17] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'd1, 2'd3};
        tbl[18] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[19] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 2'd0};
        tbl[20] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'd1, 2'd1};
        tbl[21] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1, 4'd1, 2'd1};
        tbl[22] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 1'b1, 4'd2, 2'd1};
        tbl[23] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 4'd2, 2'd1};
        tbl[24] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'd3, 2'd1};
        tbl[25] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'd3, 2'd1};

        for (int i = 0; i < 26; i++) begin
            drive_cycle(tbl[i].rst, tbl[i].wp, tbl[i].pop, 1'b0);
            chk($sformatf("vec%0d_ack", i), 32'(ackPress), 32'(tbl[i].ack));
            chk($sformatf("vec%0d_valid", i), 32'(eventValid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d_count", i), 32'(eventCount), 32'(tbl[i].cnt));
            if (tbl[i].valid) chk($sformatf("vec%0d_index", i), 32'(eventIndex), 32'(tbl[i].idx));
        end

        // Full FIFO: eight events from channel 1, then channel 0 must wait for a pop
        drive_cycle(1'b0, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 4'b0010, 1'b0, 1'b1);
            drive_cycle(1'b1, 4'b0010, 1'b0, 1'b1);
        end
        chk("full_count", 32'(eventCount), 32'd8);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 4'b0001, 1'b0, 1'b1);
            chk("full_no_ack", 32'(ackPress), 32'd0);
            chk("full_hold_count", 32'(eventCount), 32'd8);
        end
        drive_cycle(1'b1, 4'b0001, 1'b1, 1'b1);
        chk("full_pop_ack", 32'(ackPress), 32'b0001);
        chk("full_pop_count", 32'(eventCount), 32'd8);
        drive_cycle(1'b1, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_index", i), 32'(eventIndex), (i == DEPTH - 1) ? 32'd0 : 32'd1);
            drive_cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        end
        chk("drain_empty", 32'(eventValid), 32'd0);

        // Reset during the ACK cycle: queue discarded, channel re-granted right after release
        drive_cycle(1'b1, 4'b0100, 1'b0, 1'b1);
        chk("rst_pre_ack", 32'(ackPress), 32'b0100);
        drive_cycle(1'b0, 4'b0100, 1'b0, 1'b1);
        chk("rst_mid_ack", 32'(ackPress), 32'd0);
        chk("rst_mid_count", 32'(eventCount), 32'd0);
        chk("rst_mid_valid", 32'(eventValid), 32'd0);
        drive_cycle(1'b1, 4'b0100, 1'b0, 1'b1);
        chk("rst_regrant_ack", 32'(ackPress), 32'b0100);
        chk("rst_regrant_count", 32'(eventCount), 32'd1);
        chk("rst_regrant_index", 32'(eventIndex), 32'd2);

        // Random traffic: slow pops first so the FIFO fills, then fast pops
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       p;
            logic [3:0] w;
            r = ($urandom_range(0, 299) != 0);
            w = 4'($urandom);
            if (i < 1500) p = ($urandom_range(0, 4) == 0);
            else          p = ($urandom_range(0, 3) != 0);
            drive_cycle(r, w, p, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
